countdown_timer: RTL and testbench
==================================

# countdown_timer

Seconds countdown that consumes the one-second `tick` pulse produced by the 50 MHz rate divider and turns it into a game clock. Holds a two-digit BCD seconds count, supports start/pause/restart control, and signals expiry. Drives two active-low seven-segment digits directly so the top level can wire it to HEX1/HEX0.

## Interface
- `START_SECONDS`, default 60: reload value in seconds, legal range 1..99.
- `clk`  input  1: system clock, 50 MHz.
- `load`  input  1: asynchronous active-low reset.
- `tick`  input  1: one-cycle pulse from the rate divider, arbitrary spacing of at least 2 cycles.
- `start`  input  1: level, sampled each cycle; begins or resumes counting.
- `pause`  input  1: level, sampled each cycle; freezes counting.
- `restart`  input  1: level, sampled each cycle; reloads `START_SECONDS` and returns to idle.
- `tens`  output  4: BCD tens digit of the remaining count.
- `ones`  output  4: BCD ones digit of the remaining count.
- `hex1`  output  7: active-low segments {g..a} for `tens`.
- `hex0`  output  7: active-low segments {g..a} for `ones`.
- `running`  output  1: high while in RUN.
- `done`  output  1: level, high while in DONE.
- `expired`  output  1: one-cycle pulse on entry to DONE.

## Operation
- States: IDLE, RUN, PAUSED, DONE. Encoding 2 bits.
- Reset (`load` low, asynchronous): state IDLE, count = `START_SECONDS`, `running` 0, `done` 0, `expired` 0.
- Control priority each cycle: `restart` > `pause` > `start` > `tick`.
- `restart` in any state: count reloads, state to IDLE. A coincident tick is ignored.
- IDLE: `start` (without `pause`) moves to RUN. Ticks are ignored.
- RUN:
  - `pause` moves to PAUSED, and a coincident tick is ignored.
  - Otherwise a tick decrements the count.
  - A tick at count 1 sets the count to 0, moves to DONE, and pulses `expired`.
- PAUSED: `start` (without `pause`) returns to RUN. Ticks are ignored; the count is held.
- DONE: count held at 0. `start` and `pause` are ignored. Only `restart` (or reset) leaves DONE.
- BCD decrement:
  - ones 0 → 9 with a borrow from tens.
  - Otherwise ones − 1.
  - Tens never underflows, because count 0 is reached only via DONE.
  - Digits are always valid BCD (0..9).
- `start` and `pause` are levels. Holding `start` in RUN has no effect; holding `pause` keeps the block in PAUSED.
- The first decrement after `start` occurs on the next divider tick, so it lands 0..1 s later. This is intentional: the divider is free-running.

## Timing
- Registered: state, count, `expired`. Combinational from registered state/count: `running`, `done`, `tens`, `ones`, `hex1`, `hex0`.
- Tick sampled high at edge N → new count visible after edge N. That is 1-cycle latency.
- `expired` is high for exactly the cycle after the edge on which the final tick was taken, coincident with `done` first going high.
- Control inputs take effect at the next rising edge. There is no synchronizer inside; the top level synchronizes KEY/SW inputs.
- Reset asserted mid-count returns all outputs to reset values immediately (asynchronous). Counting resumes only after release plus `start`.

## Structure
- Shared package or header:
  - state encodings `ST_IDLE`=0, `ST_RUN`=1, `ST_PAUSED`=2, `ST_DONE`=3;
  - the seven-segment digit patterns.
- Sub-module `hex_decoder`: 4-bit input, 7-bit active-low output. Instantiated twice. Codes A–F are decoded as hex glyphs for reuse elsewhere.
- Top file: state register, BCD count register, priority/next-state logic, and the `expired` register.

## Test plan
- Reset with `START_SECONDS`=3, tick every 5 cycles, no start → count stays 03, `hex1`=7'b1000000, `hex0`=7'b0110000, `running`=0.
- Start, 3 ticks → count 02, 01, 00, each updating 1 cycle after its tick. `expired` is high for exactly one cycle with `done`=1. Further ticks and `start` leave 00.
- `START_SECONDS`=10, start, 1 tick → `tens`=0, `ones`=9 (borrow path). Next tick → 08.
- RUN at 05, `pause` asserted on the same cycle as a tick → PAUSED at 05. 4 ticks while paused → still 05. `start` → RUN, next tick → 04.
- `start` and `pause` both high in IDLE → stays IDLE. `restart` coincident with a tick in RUN at 02 → IDLE at 03.
- `load` pulsed low mid-RUN at 01, asynchronous to `clk` → outputs return to 03/IDLE before the next edge, and no `expired` pulse is produced.

Source files
------------

// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the seconds countdown timer: FSM state encoding and
// active-low seven-segment glyphs ({g,f,e,d,c,b,a}).
package countdown_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // A-F are drawn as hex glyphs so the decoder can be reused for hex displays.
  function automatic logic [6:0] seg7_pattern(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// Control/status bundle between the game-clock timer (slave) and whatever
// drives its controls and reads its display (master).
interface countdown_timer_if;
  import countdown_timer_pkg::*;

  // There is no valid/ready handshake here: tick is a single-cycle strobe and
  // start/pause/restart are levels sampled on every rising clock edge.
  logic       tick;
  logic       start;
  logic       pause;
  logic       restart;
  logic [3:0] tens;
  logic [3:0] ones;
  logic [6:0] hex1;
  logic [6:0] hex0;
  logic       running;
  logic       done;
  logic       expired;
  state_t     dbg_state;

  modport master (
    output tick, start, pause, restart,
    input  tens, ones, hex1, hex0, running, done, expired, dbg_state
  );

  modport slave (
    input  tick, start, pause, restart,
    output tens, ones, hex1, hex0, running, done, expired, dbg_state
  );

endinterface

// File: rtl/countdown_timer_hex_decoder.sv
// Combinational 4-bit to active-low seven-segment decoder.
module hex_decoder
  import countdown_timer_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  assign seg_o = seg7_pattern(digit_i);

endmodule

// File: rtl/countdown_timer.sv
// Two-digit BCD seconds countdown with start/pause/restart control, expiry
// pulse and direct seven-segment drive for two display digits.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int unsigned START_SECONDS = 60  // legal range 1..99
) (
  input  logic               clk,
  input  logic               load,
  countdown_timer_if.slave   bus
);

  localparam logic [3:0] START_TENS = 4'(START_SECONDS / 10);
  localparam logic [3:0] START_ONES = 4'(START_SECONDS % 10);

  state_t     state_q, state_d;
  logic [3:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;
  logic       expired_q, expired_d;
  logic       last_second;

  assign last_second = (tens_q == 4'd0) && (ones_q == 4'd1);

  always_ff @(posedge clk or negedge load) begin
    if (!load) begin
      state_q   <= ST_IDLE;
      tens_q    <= START_TENS;
      ones_q    <= START_ONES;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tens_q    <= tens_d;
      ones_q    <= ones_d;
      expired_q <= expired_d;
    end
  end

  // Priority: restart > pause > start > tick.
  always_comb begin
    state_d   = state_q;
    tens_d    = tens_q;
    ones_d    = ones_q;
    expired_d = 1'b0;
    if (bus.restart) begin
      state_d = ST_IDLE;
      tens_d  = START_TENS;
      ones_d  = START_ONES;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start && !bus.pause) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (bus.pause) begin
            state_d = ST_PAUSED;
          end else if (bus.tick) begin
            if (last_second) begin
              ones_d    = 4'd0;
              state_d   = ST_DONE;
              expired_d = 1'b1;
            end else if (ones_q == 4'd0) begin
              // Zero is only reached through DONE, so tens is nonzero here.
              ones_d = 4'd9;
              tens_d = tens_q - 4'd1;
            end else begin
              ones_d = ones_q - 4'd1;
            end
          end
        end
        ST_PAUSED: begin
          if (bus.start && !bus.pause) state_d = ST_RUN;
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  assign bus.tens      = tens_q;
  assign bus.ones      = ones_q;
  assign bus.running   = (state_q == ST_RUN);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.expired   = expired_q;
  assign bus.dbg_state = state_q;

  hex_decoder u_hex_tens (
    .digit_i (tens_q),
    .seg_o   (bus.hex1)
  );

  hex_decoder u_hex_ones (
    .digit_i (ones_q),
    .seg_o   (bus.hex0)
  );

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: two instances (3 s and 10 s reload)
// checked cycle by cycle against an integer reference model via a queue.
module tb_countdown_timer;
  import countdown_timer_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic load3;
  logic load10;

  countdown_timer_if if3 ();
  countdown_timer_if if10 ();

  countdown_timer #(.START_SECONDS(3)) dut3 (
    .clk  (clk),
    .load (load3),
    .bus  (if3)
  );

  countdown_timer #(.START_SECONDS(10)) dut10 (
    .clk  (clk),
    .load (load10),
    .bus  (if10)
  );

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;
  int exp_seen = 0;
  logic [10:0] exp_q[$];

  int m_state [2];
  int m_count [2];
  int m_reload[2];

  logic [6:0] seg_lut[10];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_reset(input int sel);
    m_state[sel] = 0;
    m_count[sel] = m_reload[sel];
  endtask

  function automatic logic [10:0] model_step(input int sel, input logic t, input logic s,
                                             input logic p, input logic r);
    logic ex;
    ex = 1'b0;
    if (r) begin
      m_state[sel] = 0;
      m_count[sel] = m_reload[sel];
    end else begin
      case (m_state[sel])
        0: if (s && !p) m_state[sel] = 1;
        1: begin
          if (p) m_state[sel] = 2;
          else if (t) begin
            m_count[sel] = m_count[sel] - 1;
            if (m_count[sel] == 0) begin
              m_state[sel] = 3;
              ex = 1'b1;
            end
          end
        end
        2: if (s && !p) m_state[sel] = 1;
        default: ;
      endcase
    end
    return {sel[0], 2'(m_state[sel]), 7'(m_count[sel]), ex};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input int sel, input logic t, input logic s, input logic p, input logic r);
    if (sel == 0) begin
      if3.tick = t; if3.start = s; if3.pause = p; if3.restart = r;
    end else begin
      if10.tick = t; if10.start = s; if10.pause = p; if10.restart = r;
    end
  endtask

  task automatic compare(input logic [10:0] item);
    int         sel;
    int         cnt;
    logic [1:0] st;
    logic [3:0] tens, ones;
    logic [6:0] h1, h0;
    logic       run, dn, ex;
    string      pfx;
    sel = int'(item[10]);
    st  = item[9:8];
    cnt = int'(item[7:1]);
    if (sel == 0) begin
      tens = if3.tens; ones = if3.ones; h1 = if3.hex1; h0 = if3.hex0;
      run = if3.running; dn = if3.done; ex = if3.expired;
      if (ex) exp_seen++;
      pfx = "d3";
    end else begin
      tens = if10.tens; ones = if10.ones; h1 = if10.hex1; h0 = if10.hex0;
      run = if10.running; dn = if10.done; ex = if10.expired;
      pfx = "d10";
    end
    check({pfx, "_tens"},    32'(tens), 32'(cnt / 10));
    check({pfx, "_ones"},    32'(ones), 32'(cnt % 10));
    check({pfx, "_hex1"},    32'(h1),   32'(seg_lut[cnt / 10]));
    check({pfx, "_hex0"},    32'(h0),   32'(seg_lut[cnt % 10]));
    check({pfx, "_running"}, 32'(run),  32'(st == 2'd1));
    check({pfx, "_done"},    32'(dn),   32'(st == 2'd3));
    check({pfx, "_expired"}, 32'(ex),   32'(item[0]));
    if (sel == 0) check({pfx, "_state"}, 32'(if3.dbg_state),  32'(st));
    else          check({pfx, "_state"}, 32'(if10.dbg_state), 32'(st));
  endtask

  task automatic cyc(input int sel, input logic t, input logic s, input logic p, input logic r);
    @(negedge clk);
    drive(sel, t, s, p, r);
    exp_q.push_back(model_step(sel, t, s, p, r));
    @(posedge clk);
    #1;
    compare(exp_q.pop_front());
  endtask

  task automatic tick_n(input int sel, input int n, input logic s, input logic p);
    repeat (n) begin
      cyc(sel, 1'b1, s, p, 1'b0);
      repeat (4) cyc(sel, 1'b0, s, p, 1'b0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int since;
    logic t, s, p, r;

    seg_lut = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    m_reload[0] = 3;
    m_reload[1] = 10;
    load3  = 1'b0;
    load10 = 1'b0;
    drive(0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1, 1'b0, 1'b0, 1'b0, 1'b0);
    model_reset(0);
    model_reset(1);

    // Reset values
    #12;
    check("rst_tens",    32'(if3.tens),      32'd0);
    check("rst_ones",    32'(if3.ones),      32'd3);
    check("rst_hex1",    32'(if3.hex1),      32'b1000000);
    check("rst_hex0",    32'(if3.hex0),      32'b0110000);
    check("rst_running", 32'(if3.running),   32'd0);
    check("rst_done",    32'(if3.done),      32'd0);
    check("rst_expired", 32'(if3.expired),   32'd0);
    check("rst_state",   32'(if3.dbg_state), 32'(ST_IDLE));
    check("rst10_count", 32'({if10.tens, if10.ones}), 32'h10);
    @(negedge clk);
    load3  = 1'b1;
    load10 = 1'b1;

    // Idle: ticks without start change nothing
    tick_n(0, 3, 1'b0, 1'b0);

    // Count 3 -> 0 with start held, then hold in DONE
    cyc(0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick_n(0, 3, 1'b1, 1'b0);
    tick_n(0, 2, 1'b1, 1'b0);
    tick_n(0, 1, 1'b0, 1'b1);
    check("done_count", 32'({if3.tens, if3.ones}), 32'h00);
    check("expired_pulses", 32'(exp_seen), 32'd1);

    // Restart, start+pause in IDLE, restart coincident with tick
    cyc(0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(0, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc(0, 1'b1, 1'b1, 1'b1, 1'b0);
    check("both_idle_state", 32'(if3.dbg_state), 32'(ST_IDLE));
    cyc(0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick_n(0, 1, 1'b0, 1'b0);
    check("run_at_02", 32'({if3.tens, if3.ones}), 32'h02);
    cyc(0, 1'b1, 1'b0, 1'b0, 1'b1);
    check("restart_tick", 32'({if3.tens, if3.ones}), 32'h03);

    // Borrow path and pause on dut10
    cyc(1, 1'b0, 1'b1, 1'b0, 1'b0);
    tick_n(1, 1, 1'b0, 1'b0);
    check("borrow_09", 32'({if10.tens, if10.ones}), 32'h09);
    tick_n(1, 1, 1'b0, 1'b0);
    check("after_08", 32'({if10.tens, if10.ones}), 32'h08);
    tick_n(1, 3, 1'b0, 1'b0);
    cyc(1, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick_n(1, 4, 1'b0, 1'b0);
    check("paused_05", 32'({if10.tens, if10.ones}), 32'h05);
    check("paused_state", 32'(if10.dbg_state), 32'(ST_PAUSED));
    cyc(1, 1'b0, 1'b1, 1'b0, 1'b0);
    tick_n(1, 1, 1'b0, 1'b0);
    check("resume_04", 32'({if10.tens, if10.ones}), 32'h04);

    // Asynchronous reset mid-run at 01
    cyc(0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick_n(0, 2, 1'b0, 1'b0);
    check("pre_async_01", 32'({if3.tens, if3.ones}), 32'h01);
    @(posedge clk);
    #3;
    load3 = 1'b0;
    #1;
    check("async_count",   32'({if3.tens, if3.ones}), 32'h03);
    check("async_state",   32'(if3.dbg_state), 32'(ST_IDLE));
    check("async_running", 32'(if3.running),   32'd0);
    check("async_hex0",    32'(if3.hex0),      32'b0110000);
    model_reset(0);
    drive(0, 1'b1, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("async_hold_count",   32'({if3.tens, if3.ones}), 32'h03);
    check("async_hold_expired", 32'(if3.expired), 32'd0);
    @(negedge clk);
    load3 = 1'b1;
    drive(0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick_n(0, 2, 1'b0, 1'b0);
    check("no_expired_after_reset", 32'(exp_seen), 32'd1);

    // Random control traffic on dut10
    cyc(1, 1'b0, 1'b0, 1'b0, 1'b1);
    since = 2;
    for (int i = 0; i < 200; i++) begin
      t = (since >= 2) && ($urandom_range(0, 2) == 0);
      s = ($urandom_range(0, 3) == 0);
      p = ($urandom_range(0, 7) == 0);
      r = ($urandom_range(0, 60) == 0);
      if (t) since = 0;
      cyc(1, t, s, p, r);
      since++;
    end

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
